// File: rtl/mux_scan_pkg.sv
// Shared constants, FSM state encoding and the channel-to-select mapping
// used by the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // The mux stage wires its select lines swapped and inverted relative to
    // the channel number: c0->11, c1->01, c2->10, c3->00.
    function automatic logic [1:0] ch2sel(input logic [1:0] c);
        return {~c[0], ~c[1]};
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Settle-time down-counter: load restarts the dwell interval, en counts it
// down, zero flags that the interval has elapsed.
module dwell_timer #(
    parameter int unsigned DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    // Loading DWELL-1 makes the SETTLE state last exactly DWELL cycles,
    // since the FSM leaves SETTLE on the cycle the count reads zero.
    localparam logic [3:0] LOAD_VAL = (DWELL == 0) ? 4'd0 : 4'(DWELL - 1);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four channels of a downstream 4:1 mux, settling DWELL cycles per
// channel, and publishes the captured 4-bit word with a one-cycle valid.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy
);

    localparam state_t CH_ENTRY = (DWELL == 0) ? SAMPLE : SETTLE;

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] shadow_q;
    logic [3:0] data_q;
    logic       tmr_load, tmr_en, tmr_zero;
    logic       capture, commit;

    dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .en   (tmr_en),
        .zero (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (capture) shadow_q[ch_q] <= mux_out;
            if (commit)  data_q <= shadow_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        capture  = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    ch_d     = '0;
                    tmr_load = 1'b1;
                    state_d  = CH_ENTRY;
                end
            end
            SETTLE: begin
                if (abort) begin
                    ch_d    = '0;
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    ch_d    = '0;
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                    if (ch_q == 2'(NUM_CH - 1)) begin
                        state_d = DONE;
                    end else begin
                        ch_d     = ch_q + 2'd1;
                        tmr_load = 1'b1;
                        state_d  = CH_ENTRY;
                    end
                end
            end
            DONE: begin
                ch_d    = '0;
                state_d = IDLE;
                commit  = !abort;
            end
            default: state_d = IDLE;
        endcase
    end

    // An abort during DONE withdraws the pulse, so data keeps its old word.
    assign sel   = ch2sel(ch_q);
    assign busy  = (state_q != IDLE);
    assign valid = (state_q == DONE) && !abort;
    assign data  = valid ? shadow_q : data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a DWELL=1 and a DWELL=0 instance, each
// driving a behavioural 4:1 mux model built from its own sel bus.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1 = 1'b0, ab1 = 1'b0, s0 = 1'b0, ab0 = 1'b0;
    logic [3:0] a = 4'b0000;
    logic [1:0] sel1, sel0;
    logic [3:0] data1, data0;
    logic       valid1, valid0, busy1, busy0;
    logic       mux1, mux0;

    int unsigned vec = 0;
    int unsigned err = 0;
    logic [3:0]  q1[$];
    logic [3:0]  q0[$];

    always #5 clk = ~clk;

    // Mux stage: sel 11->a0, 01->a1, 10->a2, 00->a3.
    function automatic logic [1:0] sel_of(input int unsigned c);
        case (c)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic mux_model(input logic [1:0] s, input logic [3:0] in);
        case (s)
            2'b11:   return in[0];
            2'b01:   return in[1];
            2'b10:   return in[2];
            default: return in[3];
        endcase
    endfunction

    assign mux1 = mux_model(sel1, a);
    assign mux0 = mux_model(sel0, a);

    mux_scan_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .abort(ab1), .mux_out(mux1),
        .sel(sel1), .data(data1), .valid(valid1), .busy(busy1)
    );

    mux_scan_ctrl #(.DWELL(0)) dut0 (
        .clk(clk), .rst(rst), .start(s0), .abort(ab0), .mux_out(mux0),
        .sel(sel0), .data(data0), .valid(valid0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec++; if ({sel1, data1, valid1, busy1} !== 8'b11_0000_0_0) begin
            err++; $display("FAIL reset_dut1 got %b want 11000000", {sel1, data1, valid1, busy1});
        end
        vec++; if ({sel0, data0, valid0, busy0} !== 8'b11_0000_0_0) begin
            err++; $display("FAIL reset_dut0 got %b want 11000000", {sel0, data0, valid0, busy0});
        end
        rst = 1'b0;
        tick();
        vec++; if (busy1 !== 1'b0) begin
            err++; $display("FAIL reset_no_autostart busy=%b want 0", busy1);
        end
    endtask

    // DWELL=1: accept edge is k=0; sel holds 2 cycles per channel, DONE after edge 8.
    task automatic test_basic();
        logic [3:0] exp_d;
        a = 4'b1010;
        q1.push_back(4'b1010);
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k < 8 && sel1 !== sel_of(k / 2)) begin
                err++; $display("FAIL basic_sel k=%0d got %b want %b", k, sel1, sel_of(k / 2));
            end
            if (k < 8) vec++;
            vec++; if (valid1 !== (k == 8)) begin
                err++; $display("FAIL basic_valid k=%0d got %b want %b", k, valid1, (k == 8));
            end
            vec++; if (busy1 !== (k <= 8)) begin
                err++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy1, (k <= 8));
            end
            if (valid1 === 1'b1 && q1.size() > 0) begin
                exp_d = q1.pop_front();
                vec++; if (data1 !== exp_d) begin
                    err++; $display("FAIL basic_data got %b want %b", data1, exp_d);
                end
            end
            tick();
        end
        vec++; if (sel1 !== 2'b11 || data1 !== 4'b1010) begin
            err++; $display("FAIL basic_idle sel/data got %b/%b want 11/1010", sel1, data1);
        end
    endtask

    // DWELL=0: one cycle per channel, DONE after edge 4.
    task automatic test_dwell0();
        logic [3:0] exp_d;
        a = 4'b1010;
        q0.push_back(4'b1010);
        s0 = 1'b1;
        tick();
        s0 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                vec++; if (sel0 !== sel_of(k)) begin
                    err++; $display("FAIL dwell0_sel k=%0d got %b want %b", k, sel0, sel_of(k));
                end
            end
            vec++; if (valid0 !== (k == 4)) begin
                err++; $display("FAIL dwell0_valid k=%0d got %b want %b", k, valid0, (k == 4));
            end
            if (valid0 === 1'b1 && q0.size() > 0) begin
                exp_d = q0.pop_front();
                vec++; if (data0 !== exp_d) begin
                    err++; $display("FAIL dwell0_data got %b want %b", data0, exp_d);
                end
            end
            tick();
        end
        vec++; if (busy0 !== 1'b0 || sel0 !== 2'b11) begin
            err++; $display("FAIL dwell0_idle busy/sel got %b/%b want 0/11", busy0, sel0);
        end
    endtask

    task automatic test_abort();
        int unsigned pulses = 0;
        a = 4'b0101;
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        repeat (4) tick();          // now in SETTLE of channel 2
        vec++; if (sel1 !== 2'b10) begin
            err++; $display("FAIL abort_pre_sel got %b want 10", sel1);
        end
        ab1 = 1'b1;
        tick();
        ab1 = 1'b0;
        vec++; if ({busy1, sel1, valid1, data1} !== 8'b0_11_0_1010) begin
            err++; $display("FAIL abort_idle got %b want 0110 1010", {busy1, sel1, valid1, data1});
        end
        for (int k = 0; k < 12; k++) begin
            if (valid1 === 1'b1) pulses++;
            tick();
        end
        vec++; if (pulses != 0 || data1 !== 4'b1010) begin
            err++; $display("FAIL abort_no_valid pulses=%0d data=%b want 0/1010", pulses, data1);
        end
        ab1 = 1'b1;                 // abort in IDLE, and abort beats start
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        tick();
        ab1 = 1'b0;
        vec++; if (busy1 !== 1'b0) begin
            err++; $display("FAIL abort_priority busy=%b want 0", busy1);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned t[$];
        logic [3:0]  exp_d;
        a = 4'b0110;
        repeat (3) q1.push_back(4'b0110);
        s1 = 1'b1;
        for (int cyc = 0; cyc < 60 && t.size() < 3; cyc++) begin
            tick();
            if (valid1 === 1'b1) begin
                t.push_back(cyc);
                if (t.size() == 3) s1 = 1'b0;
                if (q1.size() > 0) begin
                    exp_d = q1.pop_front();
                    vec++; if (data1 !== exp_d) begin
                        err++; $display("FAIL b2b_data got %b want %b", data1, exp_d);
                    end
                end
            end
        end
        s1 = 1'b0;
        vec++; if (t.size() != 3) begin
            err++; $display("FAIL b2b_count got %0d want 3", t.size());
        end else begin
            vec++; if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
                err++; $display("FAIL b2b_spacing got %0d,%0d want 10,10", t[1] - t[0], t[2] - t[1]);
            end
        end
        repeat (3) tick();
        vec++; if (busy1 !== 1'b0) begin
            err++; $display("FAIL b2b_stop busy=%b want 0", busy1);
        end
    endtask

    task automatic test_async_reset();
        int unsigned pulses = 0;
        logic [3:0]  exp_d;
        a = 4'b1111;
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        repeat (3) tick();          // SAMPLE of channel 1
        #2 rst = 1'b1;
        #1;
        vec++; if ({sel1, data1, valid1, busy1} !== 8'b11_0000_0_0) begin
            err++; $display("FAIL async_rst got %b want 11000000", {sel1, data1, valid1, busy1});
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (valid1 === 1'b1 || busy1 === 1'b1) pulses++;
        end
        vec++; if (pulses != 0) begin
            err++; $display("FAIL async_no_restart active_cycles=%0d want 0", pulses);
        end
        q1.push_back(4'b1111);
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (valid1 === 1'b1) begin
                pulses++;
                if (q1.size() > 0) begin
                    exp_d = q1.pop_front();
                    vec++; if (data1 !== exp_d) begin
                        err++; $display("FAIL async_rescan_data got %b want %b", data1, exp_d);
                    end
                end
            end
            tick();
        end
        vec++; if (pulses != 1) begin
            err++; $display("FAIL async_rescan_valid pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_start_busy();
        int unsigned pulses = 0;
        logic [3:0]  exp_d;
        a = 4'b1001;
        q1.push_back(4'b1001);
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        repeat (2) tick();          // SETTLE of channel 1
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (valid1 === 1'b1) begin
                pulses++;
                if (q1.size() > 0) begin
                    exp_d = q1.pop_front();
                    vec++; if (data1 !== exp_d) begin
                        err++; $display("FAIL busy_start_data got %b want %b", data1, exp_d);
                    end
                end
            end
            tick();
        end
        vec++; if (pulses != 1) begin
            err++; $display("FAIL busy_start_valid pulses=%0d want 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dwell0();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_start_busy();
        vec++; if (q1.size() != 0 || q0.size() != 0) begin
            err++; $display("FAIL scoreboard_drain left=%0d/%0d want 0/0", q1.size(), q0.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
